// File: rtl/rr_replay_pkg.sv
// Shared replay-tree constants and elaboration/runtime width helpers for the
// trace demarshaller family.
package rr_replay_pkg;

   localparam int unsigned RR_CHANNEL_WIDTH_BITS = 16;
   localparam int unsigned RR_GROUP_CNT_BITS     = 8;
   localparam int unsigned RR_MAX_CH             = 32;
   localparam int unsigned RR_MAX_GRP            = 16;
   localparam int unsigned RR_WIDTHS_BITS        = RR_MAX_CH * RR_CHANNEL_WIDTH_BITS;
   localparam int unsigned RR_GRP_CNTS_BITS      = RR_MAX_GRP * RR_GROUP_CNT_BITS;

   typedef logic [RR_MAX_CH-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_widths_t;
   typedef logic [RR_MAX_GRP-1:0][RR_GROUP_CNT_BITS-1:0]    rr_grp_cnts_t;

   // Total width of channels [lo, lo+cnt).
   function automatic int unsigned rr_sum_width(input rr_widths_t widths,
                                                input int unsigned lo,
                                                input int unsigned cnt);
      int unsigned s;
      s = 0;
      for (int unsigned c = 0; c < RR_MAX_CH; c++)
         if (c >= lo && c < lo + cnt) s += 32'(widths[c]);
      return s;
   endfunction

   // Static bit offset of channel ch in a fully populated beat.
   function automatic int unsigned rr_get_offset(input rr_widths_t widths,
                                                 input int unsigned ch);
      return rr_sum_width(widths, 0, ch);
   endfunction

   // First channel index owned by group k.
   function automatic int unsigned rr_group_first_ch(input rr_grp_cnts_t cnts,
                                                     input int unsigned k);
      int unsigned s;
      s = 0;
      for (int unsigned g = 0; g < RR_MAX_GRP; g++)
         if (g < k) s += 32'(cnts[g]);
      return s;
   endfunction

   // Static bit offset of group k.
   function automatic int unsigned rr_group_offset(input rr_widths_t widths,
                                                   input rr_grp_cnts_t cnts,
                                                   input int unsigned k);
      return rr_get_offset(widths, rr_group_first_ch(cnts, k));
   endfunction

   // Packed width of the valid channels below channel hi (runtime offset).
   function automatic int unsigned rr_valid_width(input rr_widths_t widths,
                                                  input logic [RR_MAX_CH-1:0] valid,
                                                  input int unsigned hi);
      int unsigned s;
      s = 0;
      for (int unsigned c = 0; c < RR_MAX_CH; c++)
         if (c < hi && valid[c]) s += 32'(widths[c]);
      return s;
   endfunction

endpackage

// File: rtl/rr_demarshal_fifo.sv
// Shift-register FIFO: head entry is always register 0, so read data,
// full and empty all come straight from flops.
module rr_demarshal_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] rd_data
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] wr_idx;
   logic             pop;
   logic             push;

   // Pop shifts toward the head; push lands just past the surviving entries.
   always_comb begin
      mem_d  = mem_q;
      pop    = !empty && rd_ready;
      push   = wr_valid && !full;
      wr_idx = cnt_q - CNT_W'(pop);
      if (pop) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) mem_d[i] = mem_q[i+1];
         mem_d[DEPTH-1] = '0;
      end
      if (push) mem_d[PTR_W'(wr_idx)] = wr_data;
      cnt_d = cnt_q - CNT_W'(pop) + CNT_W'(push);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
         cnt_q <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         mem_q <= mem_d;
         cnt_q <= cnt_d;
         full  <= (cnt_d == CNT_W'(DEPTH));
         empty <= (cnt_d == '0);
      end
   end

   assign rd_data = mem_q[0];

endmodule

// File: rtl/rr_trace_demarshaller_n.sv
// N-way replay-trace demarshaller: unpacks one packed beat into NUM_OUT channel
// groups, each buffered in its own FIFO so groups drain independently.
module rr_trace_demarshaller_n
   import rr_replay_pkg::*;
#(
   parameter int unsigned NUM_OUT          = 3,
   parameter int unsigned LOGB_CHANNEL_CNT = 4,
   parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
      {16'd12, 16'd4, 16'd16, 16'd8},
   parameter logic [NUM_OUT-1:0][RR_GROUP_CNT_BITS-1:0] GROUP_CNTS = {8'd1, 8'd2, 8'd1},
   parameter int unsigned LOGE_CHANNEL_CNT = 4,
   parameter int unsigned FIFO_DEPTH       = 4,
   parameter bit          SKIP_EMPTY       = 1'b0,
   localparam int unsigned FULL_WIDTH =
      rr_sum_width(RR_WIDTHS_BITS'(CHANNEL_WIDTHS), 0, LOGB_CHANNEL_CNT)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   input  logic [LOGB_CHANNEL_CNT-1:0]         in_logb_valid,
   input  logic [FULL_WIDTH-1:0]               in_logb_data,
   input  logic [LOGE_CHANNEL_CNT-1:0]         in_loge_valid,
   output logic                                in_ready,
   output logic [NUM_OUT-1:0]                  out_valid,
   output logic [LOGB_CHANNEL_CNT-1:0]         out_logb_valid,
   output logic [FULL_WIDTH-1:0]               out_logb_data,
   output logic [NUM_OUT*LOGE_CHANNEL_CNT-1:0] out_loge_valid,
   input  logic [NUM_OUT-1:0]                  out_ready,
   output logic [31:0]                         skip_cnt
);

   localparam int unsigned OFF_W      = $clog2(FULL_WIDTH + 1);
   localparam rr_widths_t  CW_EXT     = RR_WIDTHS_BITS'(CHANNEL_WIDTHS);
   localparam rr_grp_cnts_t GC_EXT    = RR_GRP_CNTS_BITS'(GROUP_CNTS);
   localparam int unsigned GRP_CH_SUM = rr_group_first_ch(GC_EXT, NUM_OUT);

   if (GRP_CH_SUM != LOGB_CHANNEL_CNT) begin : g_cnt_mismatch
      $error("GROUP_CNTS sum %0d != LOGB_CHANNEL_CNT %0d", GRP_CH_SUM, LOGB_CHANNEL_CNT);
   end

   logic [NUM_OUT-1:0] fifo_full;
   logic [NUM_OUT-1:0] fifo_empty;
   logic [NUM_OUT-1:0] target;
   logic               accept;
   logic [31:0]        untargeted;
   logic [32:0]        skip_sum;

   // Readiness depends only on flop state, never on the incoming beat.
   assign in_ready = !rst && !(|fifo_full);
   assign accept   = in_valid && in_ready;
   assign out_valid = ~fifo_empty;

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_grp
      localparam int unsigned FIRST_CH = rr_group_first_ch(GC_EXT, k);
      localparam int unsigned GRP_CH   = 32'(GROUP_CNTS[k]);
      localparam int unsigned GRP_W    = rr_sum_width(CW_EXT, FIRST_CH, GRP_CH);
      localparam int unsigned GRP_OFF  = rr_group_offset(CW_EXT, GC_EXT, k);
      localparam int unsigned PW       = LOGE_CHANNEL_CNT + GRP_CH + GRP_W;

      logic [OFF_W-1:0]  dyn_off;
      logic [GRP_CH-1:0] lv_slice;
      logic [GRP_W-1:0]  grp_data;
      logic [PW-1:0]     rd_data;

      // Earlier groups' valid channels sit below this group in the packed beat.
      assign dyn_off  = OFF_W'(rr_valid_width(CW_EXT, RR_MAX_CH'(in_logb_valid), FIRST_CH));
      assign grp_data = GRP_W'(in_logb_data >> dyn_off);
      assign lv_slice = in_logb_valid[FIRST_CH +: GRP_CH];
      assign target[k] = !SKIP_EMPTY || (lv_slice != '0) || (in_loge_valid != '0);

      rr_demarshal_fifo #(
         .WIDTH (PW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .wr_valid (accept && target[k]),
         .wr_data  ({in_loge_valid, lv_slice, grp_data}),
         .rd_ready (out_ready[k]),
         .full     (fifo_full[k]),
         .empty    (fifo_empty[k]),
         .rd_data  (rd_data)
      );

      assign out_logb_data[GRP_OFF +: GRP_W]   = rd_data[GRP_W-1:0];
      assign out_logb_valid[FIRST_CH +: GRP_CH] = rd_data[GRP_W +: GRP_CH];
      assign out_loge_valid[k*LOGE_CHANNEL_CNT +: LOGE_CHANNEL_CNT] =
         rd_data[GRP_W+GRP_CH +: LOGE_CHANNEL_CNT];
   end

   always_comb begin
      untargeted = '0;
      for (int unsigned k = 0; k < NUM_OUT; k++) untargeted += 32'(!target[k]);
      skip_sum = 33'(skip_cnt) + 33'(untargeted);
   end

   // Saturating count of group pushes suppressed by SKIP_EMPTY.
   always_ff @(posedge clk) begin
      if (rst)         skip_cnt <= '0;
      else if (accept) skip_cnt <= skip_sum[32] ? '1 : skip_sum[31:0];
   end

endmodule

// File: tb/tb_rr_trace_demarshaller_n.sv
// Bench for rr_trace_demarshaller_n: directed cases plus a randomized run
// against a per-group queue model of the unpacking rules.
module tb_rr_trace_demarshaller_n;

   localparam int unsigned CW [4] = '{8, 16, 4, 12};
   localparam int unsigned FC [3] = '{0, 1, 3};
   localparam int unsigned GC [3] = '{1, 2, 1};
   localparam int unsigned GW [3] = '{8, 20, 12};
   localparam int unsigned GO [3] = '{0, 8, 28};

   typedef struct packed {
      logic [3:0]  lv;
      logic [63:0] data;
      logic [3:0]  le;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready;
   logic [3:0]  in_logb_valid, in_loge_valid, out_logb_valid;
   logic [39:0] in_logb_data, out_logb_data;
   logic [2:0]  out_valid, out_ready;
   logic [11:0] out_loge_valid;
   logic [31:0] skip_cnt;

   logic        in_valid_s, in_ready_s;
   logic [3:0]  in_logb_valid_s, in_loge_valid_s, out_logb_valid_s;
   logic [39:0] in_logb_data_s, out_logb_data_s;
   logic [2:0]  out_valid_s, out_ready_s;
   logic [11:0] out_loge_valid_s;
   logic [31:0] skip_cnt_s;

   rr_trace_demarshaller_n u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_logb_valid(in_logb_valid),
      .in_logb_data(in_logb_data), .in_loge_valid(in_loge_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_logb_valid(out_logb_valid), .out_logb_data(out_logb_data),
      .out_loge_valid(out_loge_valid), .out_ready(out_ready), .skip_cnt(skip_cnt)
   );

   rr_trace_demarshaller_n #(.SKIP_EMPTY(1'b1)) u_dut_skip (
      .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_logb_valid(in_logb_valid_s),
      .in_logb_data(in_logb_data_s), .in_loge_valid(in_loge_valid_s), .in_ready(in_ready_s),
      .out_valid(out_valid_s), .out_logb_valid(out_logb_valid_s), .out_logb_data(out_logb_data_s),
      .out_loge_valid(out_loge_valid_s), .out_ready(out_ready_s), .skip_cnt(skip_cnt_s)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q [3][$];
   logic last_acc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected group payload straight from the packing rule.
   function automatic exp_t model(input int k, input logic [3:0] lv, input logic [39:0] d,
                                  input logic [3:0] le);
      exp_t        e;
      int unsigned off;
      off = 0;
      for (int c = 0; c < 4; c++)
         if (c < int'(FC[k]) && lv[c]) off += CW[c];
      e.data = (64'(d) >> off) & ((64'd1 << GW[k]) - 64'd1);
      e.lv   = (lv >> FC[k]) & 4'((1 << GC[k]) - 1);
      e.le   = le;
      return e;
   endfunction

   // Drive one cycle on the main DUT, update the model, compare at next negedge.
   task automatic step(input logic r, input logic v, input logic [3:0] lv,
                       input logic [39:0] d, input logic [3:0] le, input logic [2:0] rdy);
      logic        exp_rdy;
      logic [63:0] obs;
      rst = r; in_valid = v; in_logb_valid = lv; in_logb_data = d;
      in_loge_valid = le; out_ready = rdy;
      #1;
      exp_rdy = !r && q[0].size() < 4 && q[1].size() < 4 && q[2].size() < 4;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      last_acc = v && in_ready;
      if (r) begin
         for (int k = 0; k < 3; k++) q[k].delete();
      end else begin
         for (int k = 0; k < 3; k++)
            if (rdy[k] && q[k].size() != 0) void'(q[k].pop_front());
         if (last_acc)
            for (int k = 0; k < 3; k++) q[k].push_back(model(k, lv, d, le));
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("g%0d_valid", k), 64'(out_valid[k]), 64'(q[k].size() != 0));
         if (out_valid[k] && q[k].size() != 0) begin
            obs = (64'(out_logb_data) >> GO[k]) & ((64'd1 << GW[k]) - 64'd1);
            check($sformatf("g%0d_data", k), obs, q[k][0].data);
            obs = 64'((out_logb_valid >> FC[k]) & 4'((1 << GC[k]) - 1));
            check($sformatf("g%0d_logb_valid", k), obs, 64'(q[k][0].lv));
            check($sformatf("g%0d_loge", k), 64'(out_loge_valid[k*4 +: 4]), 64'(q[k][0].le));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 40'h0, 4'h0, 3'b111);
   endtask

   initial begin
      int          sent;
      int          beats;
      int          cyc;
      logic [2:0]  rdy;
      in_valid_s = 1'b0; in_logb_valid_s = '0; in_logb_data_s = '0;
      in_loge_valid_s = '0; out_ready_s = 3'b111;

      // Reset state
      step(1'b1, 1'b0, 4'h0, 40'h0, 4'h0, 3'b000);
      step(1'b1, 1'b0, 4'h0, 40'h0, 4'h0, 3'b000);
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_out_data", 64'(out_logb_data), 64'h0);
      check("rst_skip_cnt", 64'(skip_cnt), 64'h0);

      // Sparse beat: ch1 and ch3 valid
      step(1'b0, 1'b1, 4'b1010, 40'h00_0ABC_1234, 4'h3, 3'b000);
      check("t1_out_valid", 64'(out_valid), 64'h7);
      check("t1_g0_data", 64'(out_logb_data[7:0]), 64'h34);
      check("t1_g1_data", 64'(out_logb_data[27:8]), 64'hC1234);
      check("t1_g2_data", 64'(out_logb_data[39:28]), 64'hABC);
      check("t1_logb_valid", 64'(out_logb_valid), 64'hA);
      check("t1_loge", 64'(out_loge_valid), 64'h333);
      idle(2);

      // Full beat: static offsets
      step(1'b0, 1'b1, 4'b1111, 40'hFE_DCBA_9876, 4'h9, 3'b000);
      check("t2_g0_data", 64'(out_logb_data[7:0]), 64'h76);
      check("t2_g1_data", 64'(out_logb_data[27:8]), 64'hCBA98);
      check("t2_g2_data", 64'(out_logb_data[39:28]), 64'hFED);
      idle(2);

      // Stalled group 1 backs up the input after FIFO_DEPTH beats
      sent = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, sent < 6, 4'hF, 40'({$urandom(), $urandom()}), 4'(i), 3'b101);
         if (last_acc) sent++;
      end
      check("t3_accepted_stalled", 64'(sent), 64'd4);
      check("t3_out_valid_stalled", 64'(out_valid), 64'h2);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, sent < 6, 4'hF, 40'({$urandom(), $urandom()}), 4'(i), 3'b111);
         if (last_acc) sent++;
      end
      check("t3_accepted_total", 64'(sent), 64'd6);
      idle(2);

      // SKIP_EMPTY instance
      in_valid_s = 1'b1; in_logb_valid_s = 4'b0001; in_logb_data_s = 40'h55;
      in_loge_valid_s = 4'h0; out_ready_s = 3'b000;
      step(1'b0, 1'b0, 4'h0, 40'h0, 4'h0, 3'b111);
      check("t4_in_ready", 64'(in_ready_s), 64'h1);
      check("t4_out_valid_one", 64'(out_valid_s), 64'h1);
      check("t4_g0_data", 64'(out_logb_data_s[7:0]), 64'h55);
      check("t4_skip_two", 64'(skip_cnt_s), 64'd2);
      in_logb_valid_s = 4'b0000; in_logb_data_s = 40'h12_3456_789A; out_ready_s = 3'b111;
      step(1'b0, 1'b0, 4'h0, 40'h0, 4'h0, 3'b111);
      check("t4_out_valid_none", 64'(out_valid_s), 64'h0);
      check("t4_skip_five", 64'(skip_cnt_s), 64'd5);
      in_loge_valid_s = 4'h1;
      step(1'b0, 1'b0, 4'h0, 40'h0, 4'h0, 3'b111);
      check("t4_loge_only_all", 64'(out_valid_s), 64'h7);
      check("t4_skip_hold", 64'(skip_cnt_s), 64'd5);
      in_valid_s = 1'b0;
      step(1'b0, 1'b0, 4'h0, 40'h0, 4'h0, 3'b111);
      check("t4_drained", 64'(out_valid_s), 64'h0);

      // Reset with beats queued
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 4'($urandom()), 40'({$urandom(), $urandom()}), 4'h7, 3'b000);
      step(1'b1, 1'b0, 4'h0, 40'h0, 4'h0, 3'b000);
      check("t5_out_valid", 64'(out_valid), 64'h0);
      check("t5_out_data", 64'(out_logb_data), 64'h0);
      check("t5_skip_cnt", 64'(skip_cnt_s), 64'h0);
      check("t5_in_ready_rst", 64'(in_ready_s), 64'h0);
      step(1'b0, 1'b1, 4'b1010, 40'h00_0ABC_1234, 4'h3, 3'b000);
      check("t5_out_valid_after", 64'(out_valid), 64'h7);
      check("t5_g1_data", 64'(out_logb_data[27:8]), 64'hC1234);
      check("t5_g2_data", 64'(out_logb_data[39:28]), 64'hABC);
      idle(2);

      // Randomized traffic against the model
      beats = 0;
      cyc   = 0;
      while (beats < 10000 && cyc < 60000) begin
         for (int k = 0; k < 3; k++) rdy[k] = ($urandom_range(0, 9) < 6);
         step(1'b0, $urandom_range(0, 3) != 0, 4'($urandom()),
              40'({$urandom(), $urandom()}), 4'($urandom()), rdy);
         if (last_acc) beats++;
         cyc++;
      end
      check("random_beats", 64'(beats), 64'd10000);
      idle(8);
      check("final_drained", 64'(out_valid), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
